instruction_prefetch_queue: RTL

- Fetch front-end that sits between the instruction memory and the IF/ID pipe register of the pipelined processor.
- Runs ahead of decode: requests sequential instructions from the synchronous instruction memory (8-bit word address, 32-bit data, 1-cycle read latency).
- Buffers up to DEPTH {PC+1, instruction} entries and presents them to decode over a valid/ready handshake.
- A redirect (taken branch, jump, mispredict fix-up) flushes all buffered and in-flight fetches and restarts fetch at a new PC.

---
 rtl/instruction_prefetch_queue_pkg.sv | 20 ++
 rtl/instruction_prefetch_queue_prefetch_fifo.sv | 68 ++++++
 rtl/instruction_prefetch_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   IMEM_AW       : instruction memory word-address (PC) width
//   INSTR_W       : instruction width
//   fetch_entry_t : one buffered fetch, {address of the next instruction, instruction}
//   count_width() : bits needed to hold an occupancy of 0..depth
package instruction_prefetch_queue_pkg;

  localparam int IMEM_AW = 8;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [IMEM_AW-1:0] pc_plus1;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instruction_prefetch_queue_prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO holding prefetched instructions.
//   clk, rst  : rising-edge clock, asynchronous active-low reset
//   flush     : synchronous clear of pointers and count (wins over wr_en/rd_en)
//   wr_en     : push wr_data at the tail
//   rd_en     : pop the head; rd_data always shows the current head
//   count     : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module instruction_prefetch_queue_prefetch_fifo
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  entry_t                        wr_data,
  input  logic                          rd_en,
  output entry_t                        rd_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // count define which words are meaningful, and leaving it out of reset
  // lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

`ifndef SYNTHESIS
  overflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(wr_en && !rd_en && !flush && (count == CW'(DEPTH))))
    else $error("prefetch_fifo: write into a full queue");
`endif

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Fetch front-end between the synchronous instruction memory and IF/ID.
// Runs ahead of decode, buffering up to DEPTH {pc+1, instruction} entries.
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   enable            : 0 freezes issue and dequeue (responses still captured)
//   redirect          : flush everything and restart fetch at redirect_pc
//   imem_addr/rden/q  : memory read port, data one cycle after rden
//   deq_valid/ready   : handshake to decode; deq_instr/deq_pc_plus1 = head
//   fetch_pc          : next sequential address to request
//   count             : stored entries
module instruction_prefetch_queue
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = IMEM_AW,
  parameter int DW    = INSTR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          redirect,
  input  logic [AW-1:0]                 redirect_pc,
  output logic [AW-1:0]                 imem_addr,
  output logic                          imem_rden,
  input  logic [DW-1:0]                 imem_q,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [DW-1:0]                 deq_instr,
  output logic [AW-1:0]                 deq_pc_plus1,
  output logic [AW-1:0]                 fetch_pc,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc_plus1;
    logic [DW-1:0] instr;
  } entry_t;

  logic          inflight;   // a read was issued last cycle; its data is on imem_q now
  logic [AW-1:0] tag;        // address of that read
  logic [CW:0]   committed;  // slots already spoken for: stored + in flight
  logic          credit_ok;
  logic          capture;
  logic          pop;
  entry_t        wr_entry;
  entry_t        head;

  // A same-cycle pop is intentionally not credited, keeping the issue path
  // independent of deq_ready.
  assign committed = {1'b0, count} + (CW+1)'(inflight);
  assign credit_ok = committed < (CW+1)'(DEPTH);

  // NOTE: every output of this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    imem_rden = 1'b0;
    imem_addr = '0;
    if (rst) begin
      if (redirect) begin
        // The queue empties this cycle, so credit is irrelevant.
        imem_rden = enable;
        imem_addr = redirect_pc;
      end else begin
        imem_rden = enable & credit_ok;
        imem_addr = fetch_pc;
      end
    end
  end

  // Whatever address was issued, the next sequential one follows it; an
  // unissued redirect still moves the fetch point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= '0;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= imem_rden;
      if (imem_rden) begin
        tag      <= imem_addr;
        fetch_pc <= imem_addr + AW'(1);
      end else if (redirect) begin
        fetch_pc <= redirect_pc;
      end
    end
  end

  // Memory data is captured even with enable low; a redirect squashes it.
  assign capture  = inflight & ~redirect;
  assign wr_entry = '{pc_plus1: tag + AW'(1), instr: imem_q};

  // The redirect gate is combinational so decode never consumes a stale head.
  assign deq_valid    = (count != '0) & enable & ~redirect;
  assign pop          = deq_valid & deq_ready;
  assign deq_instr    = head.instr;
  assign deq_pc_plus1 = head.pc_plus1;

  instruction_prefetch_queue_prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_prefetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

endmodule
